// File: rtl/logic_op_pkg.sv
// Shared opcode encodings for the logic issuer and the logic unit it drives.
// Also holds the response-register state type.
package logic_op_pkg;
    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_AND     = 3'b000;
    localparam logic [OP_W-1:0] OP_OR      = 3'b001;
    localparam logic [OP_W-1:0] OP_XOR     = 3'b010;
    localparam logic [OP_W-1:0] OP_NOT     = 3'b011;
    localparam logic [OP_W-1:0] OP_NAND    = 3'b100;
    localparam logic [OP_W-1:0] OP_NOR     = 3'b101;
    localparam logic [OP_W-1:0] OP_XNOR    = 3'b110;
    localparam logic [OP_W-1:0] OP_ILLEGAL = 3'b111;

    typedef enum logic {
        RSP_EMPTY = 1'b0,
        RSP_FULL  = 1'b1
    } rsp_state_e;
endpackage

// File: rtl/logic_cmd_fifo.sv
// Synchronous FIFO with extra-MSB pointers: full when MSBs differ and the rest match.
// Flush and reset both empty it; storage is not cleared since reads are masked when empty.
module logic_cmd_fifo #(
    parameter int W     = 11,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [AW:0]  r_wr_ptr;
    logic [AW:0]  r_rd_ptr;
    logic [W-1:0] r_mem [DEPTH];
    logic         w_do_push;
    logic         w_do_pop;

    assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign empty = (r_wr_ptr == r_rd_ptr);
    assign rdata = r_mem[r_rd_ptr[AW-1:0]];

    assign w_do_push = push && !full && !flush && !rst;
    assign w_do_pop  = pop && !empty && !flush && !rst;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= wdata;
    end
endmodule

// File: rtl/logic_unit.sv
// Combinational bitwise logic unit; lives outside the issuer and is paired with it at integration.
// The illegal opcode produces zero.
module logic_unit
    import logic_op_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result
);
    always_comb begin
        result = '0;
        case (op)
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_NOT:  result = ~a;
            OP_NAND: result = ~(a & b);
            OP_NOR:  result = ~(a | b);
            OP_XNOR: result = ~(a ^ b);
            default: result = '0;
        endcase
    end
endmodule

// File: rtl/logic_op_issuer.sv
// Command front end for the logic unit: FIFO-buffered {op,a,b} commands out on lu_*,
// result captured into a registered valid/ready response at one command per cycle.
module logic_op_issuer
    import logic_op_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [OP_W-1:0]  cmd_op,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    output logic [OP_W-1:0]  lu_op,
    output logic [WIDTH-1:0] lu_a,
    output logic [WIDTH-1:0] lu_b,
    input  logic [WIDTH-1:0] lu_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic [OP_W-1:0]  rsp_op,
    output logic             rsp_illegal,
    output logic             busy,
    output logic [CNT_W-1:0] issued_count,
    output rsp_state_e       dbg_rsp_state
);
    localparam int ENT_W = OP_W + 2 * WIDTH;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    // Handshakes: a transfer happens on a rising edge where valid && ready;
    // the sender holds its payload stable until then.
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_issue;
    logic [ENT_W-1:0] w_head;
    rsp_state_e       r_state;
    rsp_state_e       w_state_nxt;
    logic [WIDTH-1:0] r_rsp_result;
    logic [OP_W-1:0]  r_rsp_op;
    logic             r_rsp_illegal;
    logic [CNT_W-1:0] r_count;

    assign cmd_ready = !w_full && !flush && !rst;
    assign w_push    = cmd_valid && cmd_ready;
    assign rsp_valid = (r_state == RSP_FULL);
    assign w_issue   = !w_empty && (!rsp_valid || rsp_ready) && !flush && !rst;

    logic_cmd_fifo #(
        .W     (ENT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (w_push),
        .pop   (w_issue),
        .wdata ({cmd_op, cmd_a, cmd_b}),
        .rdata (w_head),
        .full  (w_full),
        .empty (w_empty)
    );

    assign lu_op = w_empty ? '0 : w_head[2*WIDTH +: OP_W];
    assign lu_a  = w_empty ? '0 : w_head[WIDTH +: WIDTH];
    assign lu_b  = w_empty ? '0 : w_head[0 +: WIDTH];

    always_ff @(posedge clk) begin
        if (rst) r_state <= RSP_EMPTY;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RSP_EMPTY: if (w_issue) w_state_nxt = RSP_FULL;
            RSP_FULL:  if (!w_issue && rsp_ready) w_state_nxt = RSP_EMPTY;
            default:   w_state_nxt = RSP_EMPTY;
        endcase
        if (flush) w_state_nxt = RSP_EMPTY;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_result  <= '0;
            r_rsp_op      <= '0;
            r_rsp_illegal <= 1'b0;
            r_count       <= '0;
        end else if (flush) begin
            r_count <= '0;
        end else if (w_issue) begin
            r_rsp_result  <= lu_result;
            r_rsp_op      <= lu_op;
            r_rsp_illegal <= (lu_op == OP_ILLEGAL);
            r_count       <= r_count + CNT_ONE;
        end
    end

    assign rsp_result    = r_rsp_result;
    assign rsp_op        = r_rsp_op;
    assign rsp_illegal   = r_rsp_illegal;
    assign issued_count  = r_count;
    assign busy          = !w_empty || rsp_valid;
    assign dbg_rsp_state = r_state;
endmodule

// File: tb/tb_logic_op_issuer.sv
// Directed bench for logic_op_issuer with the logic unit closing the lu_* loop;
// responses are checked in order against an expected queue.
module tb_logic_op_issuer;
    import logic_op_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [3:0] cmd_a;
    logic [3:0] cmd_b;
    logic [2:0] lu_op;
    logic [3:0] lu_a;
    logic [3:0] lu_b;
    logic [3:0] lu_result;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [3:0] rsp_result;
    logic [2:0] rsp_op;
    logic       rsp_illegal;
    logic       busy;
    logic [7:0] issued_count;
    rsp_state_e dbg_rsp_state;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    logic_op_issuer #(.WIDTH(4), .DEPTH(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .lu_op(lu_op), .lu_a(lu_a), .lu_b(lu_b), .lu_result(lu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_op(rsp_op), .rsp_illegal(rsp_illegal),
        .busy(busy), .issued_count(issued_count), .dbg_rsp_state(dbg_rsp_state)
    );

    logic_unit #(.WIDTH(4)) u_lu (.op(lu_op), .a(lu_a), .b(lu_b), .result(lu_result));

    function automatic logic [7:0] model(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        logic [3:0] r;
        case (op)
            3'd0: r = a & b;
            3'd1: r = a | b;
            3'd2: r = a ^ b;
            3'd3: r = ~a;
            3'd4: r = ~(a & b);
            3'd5: r = ~(a | b);
            3'd6: r = ~(a ^ b);
            default: r = 4'h0;
        endcase
        return {(op == 3'd7), op, r};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
    endtask

    task automatic wait_idle();
        for (int g = 0; g < 40; g++) begin
            if (!busy) break;
            step();
        end
        check("drain_timeout_busy", busy, 0);
        check("drain_queue_empty", exp_q.size(), 0);
    endtask

    // Scoreboard: a response leaves on valid&&ready, a command enters on valid&&ready.
    always @(negedge clk) begin
        logic [7:0] e;
        if (rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", {rsp_illegal, rsp_op, rsp_result}, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("rsp_order", {rsp_illegal, rsp_op, rsp_result}, e);
            end
        end
        if (rst || flush) exp_q.delete();
        else if (cmd_valid && cmd_ready) exp_q.push_back(model(cmd_op, cmd_a, cmd_b));
    end

    logic [3:0] t2_exp [7];
    logic [3:0] sa [5];
    logic [3:0] sb [5];

    initial begin
        t2_exp[0] = 4'h8; t2_exp[1] = 4'hE; t2_exp[2] = 4'h6; t2_exp[3] = 4'h3;
        t2_exp[4] = 4'h7; t2_exp[5] = 4'h1; t2_exp[6] = 4'h9;
        rst = 1'b1; flush = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0;
        rsp_ready = 1'b1;

        // reset state
        step(); step();
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_result", rsp_result, 0);
        check("rst_rsp_op", rsp_op, 0);
        check("rst_rsp_illegal", rsp_illegal, 0);
        check("rst_count", issued_count, 0);
        check("rst_busy", busy, 0);
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_lu_op", lu_op, 0);
        rst = 1'b0;
        #1;
        check("post_rst_cmd_ready", cmd_ready, 1);

        // 1: single AND, latency
        drive(3'd0, 4'hC, 4'hA);
        step();
        cmd_valid = 1'b0;
        check("t1_head_lu_a", lu_a, 4'hC);
        check("t1_head_lu_b", lu_b, 4'hA);
        check("t1_no_rsp_yet", rsp_valid, 0);
        step();
        check("t1_rsp_valid", rsp_valid, 1);
        check("t1_state", 32'(dbg_rsp_state), 32'(RSP_FULL));
        check("t1_result", rsp_result, 4'h8);
        check("t1_op", rsp_op, 0);
        check("t1_count", issued_count, 1);
        wait_idle();

        // 2: seven legal ops back to back
        for (int i = 0; i < 7; i++) begin
            drive(3'(i), 4'hC, 4'hA);
            step();
            if (i > 0) begin
                check("t2_rsp_valid", rsp_valid, 1);
                check("t2_op", rsp_op, i - 1);
                check("t2_result", rsp_result, t2_exp[i-1]);
            end
        end
        cmd_valid = 1'b0;
        step();
        check("t2_last_valid", rsp_valid, 1);
        check("t2_last_result", rsp_result, t2_exp[6]);
        check("t2_count", issued_count, 8);
        wait_idle();

        // 3: stall with full FIFO, then release
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sa[i] = 4'($urandom_range(0, 15));
            sb[i] = 4'($urandom_range(0, 15));
            drive(3'(i), sa[i], sb[i]);
            step();
        end
        drive(3'd6, 4'h5, 4'h5);
        #1;
        check("t3_full_cmd_ready", cmd_ready, 0);
        check("t3_held_op", rsp_op, 0);
        step(); step();
        cmd_valid = 1'b0;
        check("t3_still_full", cmd_ready, 0);
        check("t3_held_result", rsp_result, 32'(model(3'd0, sa[0], sb[0]) & 8'h0F));
        check("t3_held_valid", rsp_valid, 1);
        rsp_ready = 1'b1;
        #1;
        check("t3_ready_before_pop", cmd_ready, 0);
        step();
        check("t3_ready_after_pop", cmd_ready, 1);
        check("t3_next_op", rsp_op, 1);
        wait_idle();

        // 4: illegal op does not stall
        drive(3'd7, 4'hF, 4'hF);
        step();
        drive(3'd0, 4'hF, 4'h3);
        step();
        cmd_valid = 1'b0;
        check("t4_ill_result", rsp_result, 0);
        check("t4_ill_flag", rsp_illegal, 1);
        check("t4_ill_op", rsp_op, 7);
        step();
        check("t4_next_valid", rsp_valid, 1);
        check("t4_next_flag", rsp_illegal, 0);
        check("t4_next_result", rsp_result, 4'h3);
        wait_idle();

        // 5: flush with queued work and a simultaneous command
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(3'(i), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            step();
        end
        drive(3'd5, 4'h0, 4'h0);
        flush = 1'b1;
        #1;
        check("t5_flush_cmd_ready", cmd_ready, 0);
        check("t5_pre_rsp_valid", rsp_valid, 1);
        step();
        flush = 1'b0;
        cmd_valid = 1'b0;
        check("t5_busy", busy, 0);
        check("t5_rsp_valid", rsp_valid, 0);
        check("t5_count", issued_count, 0);
        check("t5_lu_op", lu_op, 0);
        rsp_ready = 1'b1;
        step(); step(); step();
        check("t5_nothing_after", rsp_valid, 0);

        // 6: reset mid-stream, then count wrap
        for (int i = 0; i < 3; i++) begin
            drive(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            step();
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        cmd_valid = 1'b0;
        check("t6_rsp_valid", rsp_valid, 0);
        check("t6_rsp_result", rsp_result, 0);
        check("t6_rsp_op", rsp_op, 0);
        check("t6_rsp_illegal", rsp_illegal, 0);
        check("t6_count", issued_count, 0);
        check("t6_busy", busy, 0);
        for (int i = 0; i < 255; i++) begin
            drive(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            step();
        end
        cmd_valid = 1'b0;
        wait_idle();
        check("t6_count_255", issued_count, 255);
        drive(3'd1, 4'h3, 4'h4);
        step();
        cmd_valid = 1'b0;
        wait_idle();
        check("t6_count_wrap", issued_count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
